// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Requester slots on the shared memory/bus path
    localparam int REQ_IF  = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_DMA = 2;
    localparam int REQ_DBG = 3;

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest slot back to ptr so the nearest hit wins last
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4-way data mux.
// A grant is held until done, owner withdrawal or timeout; on release the
// next winner is granted on the same edge so back-to-back owners see no bubble.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]       gnt_d;
    logic [SEL_W-1:0]       sel_d;
    logic                   busy_d;
    logic                   timeout_d;

    logic                   pick_found;
    logic [SEL_W-1:0]       pick_idx;
    logic                   owner_req;
    logic                   to_hit;
    logic                   release_now;

    // One picker serves both the idle grant and the release regrant
    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req   = req[sel];
    assign to_hit      = (TIMEOUT != 0) && (cnt_q == CNT_WIDTH'(TIMEOUT - 1));
    assign release_now = done || !owner_req || to_hit;

    // State, grant and counter registers; reset aborts any grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            sel     <= sel_d;
            busy    <= busy_d;
            timeout <= timeout_d;
        end
    end

    // Next-state: grant from idle, hold or release/regrant while busy
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt;
        sel_d     = sel;
        busy_d    = busy;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d        = BUSY;
                    gnt_d          = '0;
                    gnt_d[pick_idx] = 1'b1;
                    sel_d          = pick_idx;
                    busy_d         = 1'b1;
                    cnt_d          = '0;
                    ptr_d          = pick_idx + SEL_W'(1);
                end
            end
            BUSY: begin
                if (release_now) begin
                    // Only a pure timeout (owner still requesting, no done) pulses
                    timeout_d = !done && owner_req && to_hit;
                    cnt_d     = '0;
                    if (pick_found) begin
                        gnt_d           = '0;
                        gnt_d[pick_idx] = 1'b1;
                        sel_d           = pick_idx;
                        busy_d          = 1'b1;
                        ptr_d           = pick_idx + SEL_W'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (TIMEOUT=4) with a reference
// model feeding an expectation queue.
module tb_mux4_rr_arbiter;
    import mux4_rr_arbiter_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    mux4_rr_arbiter #(.TIMEOUT(TO), .CNT_WIDTH(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Expected {gnt, sel, busy, timeout} after each edge
    logic [7:0] sb[$];
    logic [7:0] e;

    // Reference model state
    bit       m_busy;
    int       m_owner, m_ptr, m_cnt;
    bit       m_tmo;
    int       m_sel;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_tmo = 0;
        sb.delete();
    endtask

    // Apply inputs, advance the model one edge, push expectation, clock DUT
    task automatic drive_cycle(input logic [3:0] r, input logic d);
        int w;
        bit rel;
        logic [3:0] g;
        req = r; done = d;
        m_tmo = 0;
        if (!m_busy) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_ptr = (w + 1) % 4; m_cnt = 0;
            end
        end else begin
            rel = d || !r[m_sel] || (m_cnt == TO - 1);
            if (rel) begin
                m_tmo = !d && r[m_sel] && (m_cnt == TO - 1);
                m_cnt = 0;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_sel = w; m_ptr = (w + 1) % 4;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_cnt++;
            end
        end
        g = m_busy ? (4'b0001 << m_sel) : 4'b0000;
        sb.push_back({g, 2'(m_sel), m_busy ? 1'b1 : 1'b0, m_tmo ? 1'b1 : 1'b0});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0; done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({gnt, sel, busy, timeout} !== 8'b0000_00_0_0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b required=%b", {gnt, sel, busy, timeout}, 8'b0);
        end
        rst_n = 1'b1;
        model_reset();
        drive_cycle(4'b0001, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if ({gnt, sel, busy, timeout} !== e || gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant got=%b required=%b", {gnt, sel, busy, timeout}, e);
        end
        // done ends the grant with nothing pending: back to idle, sel kept
        drive_cycle(4'b0000, 1'b1);
        e = sb.pop_front();
        n_chk++;
        if ({gnt, sel, busy, timeout} !== e || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_to_idle got=%b required=%b", {gnt, sel, busy, timeout}, e);
        end
    endtask

    task automatic test_rotation();
        int exp_sel[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive_cycle(4'b1111, (i % 3 == 0) && (i > 0));
            e = sb.pop_front();
            n_chk++;
            if ({gnt, sel, busy, timeout} !== e || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rotation[%0d] got=%b required=%b", i, {gnt, sel, busy, timeout}, e);
            end
            if (i % 3 == 0) begin
                n_chk++;
                if (sel !== 2'(exp_sel[i / 3])) begin
                    n_fail++;
                    $display("FAIL rotation_sel[%0d] got=%0d required=%0d", i, sel, exp_sel[i / 3]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] rv[4]  = '{4'b0010, 4'b0011, 4'b0010, 4'b0010};
        logic       dv[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] sv[4]  = '{2'd1, 2'd0, 2'd1, 2'd1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(rv[i], dv[i]);
            e = sb.pop_front();
            n_chk++;
            if ({gnt, sel, busy, timeout} !== e || sel !== sv[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL fairness[%0d] got=%b required=%b sel_req=%0d", i, {gnt, sel, busy, timeout}, e, sv[i]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        // grant at edge 0, forced release at edge 4, done wins at edge 8
        for (int i = 0; i < 10; i++) begin
            drive_cycle((i == 9) ? 4'b0000 : 4'b0100, (i == 8));
            e = sb.pop_front();
            n_chk++;
            if ({gnt, sel, busy, timeout} !== e) begin
                n_fail++;
                $display("FAIL timeout_seq[%0d] got=%b required=%b", i, {gnt, sel, busy, timeout}, e);
            end
            n_chk++;
            if (timeout !== ((i == 4) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL timeout_pulse[%0d] got=%b required=%b", i, timeout, (i == 4));
            end
        end
        n_chk++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle got gnt=%b busy=%b required gnt=0000 busy=0", gnt, busy);
        end
    endtask

    task automatic test_withdrawal();
        logic [3:0] rv[3] = '{4'b1000, 4'b1001, 4'b0001};
        logic [3:0] gv[3] = '{4'b1000, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(rv[i], 1'b0);
            e = sb.pop_front();
            n_chk++;
            if ({gnt, sel, busy, timeout} !== e || gnt !== gv[i] || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL withdrawal[%0d] got=%b required=%b", i, {gnt, sel, busy, timeout}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_cycle(4'b0100, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if ({gnt, sel, busy, timeout} !== e) begin
            n_fail++;
            $display("FAIL areset_grant got=%b required=%b", {gnt, sel, busy, timeout}, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_immediate got gnt=%b sel=%0d busy=%b required 0", gnt, sel, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive_cycle(4'b1111, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if ({gnt, sel, busy, timeout} !== e || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_ptr got=%b required=%b", {gnt, sel, busy, timeout}, e);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_fairness();
        test_timeout();
        test_withdrawal();
        test_async_reset();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
